// File: rtl/set_assoc_cache_if.sv
// Geometry/types for the set-associative cache, plus the bundled lookup and
// write port seen by the memory-side controller (master) and the cache (slave).
package cache_pkg;
  localparam int SetWidth      = 4;
  localparam int TagWidth      = 8;
  localparam int Associativity = 4;
  localparam int WayWidth      = $clog2(Associativity);
  localparam int DataWidth     = 32;
  localparam int NumSets       = 2 ** SetWidth;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef logic [DataWidth-1:0] block_data_t;
endpackage

interface set_assoc_cache_if;
  import cache_pkg::*;

  logic [SetWidth-1:0]                  read_set_i;
  logic [TagWidth-1:0]                  read_tag_i;
  logic                                 read_hit_o;
  logic [WayWidth-1:0]                  read_way_o;
  block_data_t                          read_data_o;
  logic                                 write_en_i;
  logic [SetWidth-1:0]                  write_set_i;
  block_info_t [Associativity-1:0]      write_info_i;
  logic [WayWidth-1:0]                  write_data_way_i;
  block_data_t                          write_data_i;

  modport slave (
    input  read_set_i, read_tag_i,
    output read_hit_o, read_way_o, read_data_o,
    input  write_en_i, write_set_i, write_info_i, write_data_way_i, write_data_i
  );

  modport master (
    output read_set_i, read_tag_i,
    input  read_hit_o, read_way_o, read_data_o,
    output write_en_i, write_set_i, write_info_i, write_data_way_i, write_data_i
  );
endinterface

// File: rtl/set_assoc_cache.sv
// Set-associative tag/data store: combinational lookup, one synchronous write
// port that rewrites a whole set's metadata and one way's data block.
module set_assoc_cache
  import cache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  set_assoc_cache_if.slave   bus
);

  block_info_t [Associativity-1:0] info_q [NumSets];
  block_info_t [Associativity-1:0] info_d [NumSets];
  block_data_t                     data_q [NumSets][Associativity];
  block_data_t                     data_d [NumSets][Associativity];

  logic [Associativity-1:0] match;
  logic [WayWidth-1:0]      hit_way;

  always_comb begin
    info_d = info_q;
    data_d = data_q;
    if (bus.write_en_i) begin
      info_d[bus.write_set_i]                       = bus.write_info_i;
      data_d[bus.write_set_i][bus.write_data_way_i] = bus.write_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSets; s++) begin
        for (int w = 0; w < Associativity; w++) begin
          info_q[s][w] <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      info_q <= info_d;
      data_q <= data_d;
    end
  end

  // Duplicate tags resolve to the lowest matching way: scan high to low so
  // the last assignment wins.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < Associativity; w++) begin
      match[w] = info_q[bus.read_set_i][w].valid &&
                 (info_q[bus.read_set_i][w].tag == bus.read_tag_i);
    end
    for (int w = Associativity - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WayWidth'(w);
    end
  end

  assign bus.read_hit_o  = |match;
  assign bus.read_way_o  = hit_way;
  assign bus.read_data_o = (|match) ? data_q[bus.read_set_i][hit_way] : '0;

  write_way_known: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.write_en_i |-> !$isunknown(bus.write_data_way_i)
  );

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache: reset, fill, misses,
// write-enable gating, duplicate-tag priority and asynchronous reset.
module tb_set_assoc_cache;
  import cache_pkg::*;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  block_data_t d_val [Associativity];
  block_data_t dup_data;

  set_assoc_cache_if bus ();

  set_assoc_cache dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a lookup and sample it at the following falling edge.
  task automatic check_lookup(input string tag, input logic [SetWidth-1:0] set_idx,
                              input logic [TagWidth-1:0] tag_val, input logic exp_hit,
                              input logic [WayWidth-1:0] exp_way,
                              input block_data_t exp_data);
    bus.read_set_i = set_idx;
    bus.read_tag_i = tag_val;
    @(negedge clk_i);
    check_value({tag, "_hit"},  64'(bus.read_hit_o),  64'(exp_hit));
    check_value({tag, "_way"},  64'(bus.read_way_o),  64'(exp_way));
    check_value({tag, "_data"}, 64'(bus.read_data_o), 64'(exp_data));
  endtask

  task automatic set_info(input int way, input logic valid, input logic [TagWidth-1:0] tag);
    bus.write_info_i[way].valid = valid;
    bus.write_info_i[way].tag   = tag;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.read_set_i       = '0;
    bus.read_tag_i       = '0;
    bus.write_en_i       = 1'b0;
    bus.write_set_i      = '0;
    bus.write_info_i     = '0;
    bus.write_data_way_i = '0;
    bus.write_data_i     = '0;
    for (int i = 0; i < Associativity; i++) d_val[i] = block_data_t'($urandom) | 32'h1;
    dup_data = 32'hC0DE_0007;

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check_lookup("reset_s0_t0", 0, 0, 1'b0, 0, '0);

    // Fill set 0: ways tagged 0..3, one data word per cycle.
    bus.write_en_i  = 1'b1;
    bus.write_set_i = 0;
    for (int i = 0; i < Associativity; i++) set_info(i, 1'b1, TagWidth'(i));
    for (int i = 0; i < Associativity; i++) begin
      bus.write_data_way_i = WayWidth'(i);
      bus.write_data_i     = d_val[i];
      @(negedge clk_i);
    end
    bus.write_en_i = 1'b0;

    for (int i = 0; i < Associativity; i++)
      check_lookup($sformatf("fill_t%0d", i), 0, TagWidth'(i), 1'b1, WayWidth'(i), d_val[i]);

    check_lookup("miss_s0_t4", 0, 4, 1'b0, 0, '0);
    check_lookup("miss_s1_t0", 1, 0, 1'b0, 0, '0);

    // Invalidate way 2, re-presenting its existing data.
    bus.write_en_i = 1'b1;
    set_info(2, 1'b0, 2);
    bus.write_data_way_i = 2;
    bus.write_data_i     = d_val[2];
    @(negedge clk_i);
    bus.write_en_i = 1'b0;
    check_lookup("inval_t2", 0, 2, 1'b0, 0, '0);
    check_lookup("inval_t0", 0, 0, 1'b1, 0, d_val[0]);
    check_lookup("inval_t1", 0, 1, 1'b1, 1, d_val[1]);
    check_lookup("inval_t3", 0, 3, 1'b1, 3, d_val[3]);

    // Write-enable low: different payload must not land.
    for (int i = 0; i < Associativity; i++) set_info(i, 1'b1, 9);
    bus.write_data_way_i = 0;
    bus.write_data_i     = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk_i);
    check_lookup("gate_t0", 0, 0, 1'b1, 0, d_val[0]);
    check_lookup("gate_t3", 0, 3, 1'b1, 3, d_val[3]);
    check_lookup("gate_t9", 0, 9, 1'b0, 0, '0);

    // Duplicate tag 7 in ways 1 and 3: lowest way wins.
    bus.write_en_i = 1'b1;
    set_info(0, 1'b1, 0);
    set_info(1, 1'b1, 7);
    set_info(2, 1'b0, 2);
    set_info(3, 1'b1, 7);
    bus.write_data_way_i = 1;
    bus.write_data_i     = dup_data;
    @(negedge clk_i);
    bus.write_en_i = 1'b0;
    check_lookup("dup_t7", 0, 7, 1'b1, 1, dup_data);
    check_lookup("dup_t0", 0, 0, 1'b1, 0, d_val[0]);

    // Asynchronous reset between clock edges.
    bus.read_set_i = 0;
    bus.read_tag_i = 0;
    #2;
    check_value("pre_rst_hit", 64'(bus.read_hit_o), 64'(1'b1));
    rst_ni = 1'b0;
    #1;
    check_value("async_rst_hit",  64'(bus.read_hit_o),  64'(1'b0));
    check_value("async_rst_data", 64'(bus.read_data_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_lookup("post_rst_t0", 0, 0, 1'b0, 0, '0);
    check_lookup("post_rst_t7", 0, 7, 1'b0, 0, '0);
    check_lookup("post_rst_t3", 0, 3, 1'b0, 0, '0);

    // Rewrite after reset restores a hit.
    bus.write_en_i = 1'b1;
    bus.write_info_i = '0;
    set_info(0, 1'b1, 8'h42);
    bus.write_data_way_i = 0;
    bus.write_data_i     = 32'h0000_0055;
    @(negedge clk_i);
    bus.write_en_i = 1'b0;
    check_lookup("rewrite_t42", 0, 8'h42, 1'b1, 0, 32'h0000_0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
